reg_hazard_tracker: RTL

//  Read-side partner to the pipeline's 5-bit destination-register (Rd) registers.

---
 rtl/reg_hazard_tracker_pkg.sv | 34 +++
 rtl/reg_hazard_tracker_pipe_slot.sv | 28 ++
 rtl/reg_hazard_tracker.sv | 134 +++++++++++++
 3 files changed

// File: rtl/reg_hazard_tracker_pkg.sv
// Shared types and constants for the register hazard tracker.
// Optional feature macro: HAZARD_WB_BYPASS_EN (WB slot takes part in forwarding).
package hazard_pkg;

  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              memread;
  } slot_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, rd: 5'd0, memread: 1'b0};

  // A slot supplies a source only when it holds a live producer of that
  // register; XZR never matches, even if it somehow got into a slot.
  function automatic logic slot_matches(slot_t s, logic [ADDR_W-1:0] src);
    return s.valid && (s.rd == src) && (src != ZERO_REG);
  endfunction

endpackage

// File: rtl/reg_hazard_tracker_pipe_slot.sv
// One in-flight destination-register slot: loads a new entry or a bubble
// each cycle; synchronous active-high reset empties it.
module pipe_slot
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  slot_t d,
  output slot_t q
);

  slot_t slot_q;

  // Slot register: reset or bubble clears it, load captures the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= SLOT_BUBBLE;
    end else if (load) begin
      slot_q <= d;
    end else begin
      slot_q <= SLOT_BUBBLE;
    end
  end

  assign q = slot_q;

endmodule

// File: rtl/reg_hazard_tracker.sv
// Register hazard tracker: follows in-flight Rd numbers through EX/MEM/WB,
// produces operand forwarding selects and a one-cycle load-use stall.
// Optional feature macro: HAZARD_WB_BYPASS_EN -- when defined the WB slot
// can be forwarded (select 11); otherwise the register file's write-first
// behaviour covers that case and the WB slot is tracked but never selected.
module reg_hazard_tracker
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [ADDR_W-1:0] id_rn,
  input  logic [ADDR_W-1:0] id_rm,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall
);

`ifdef HAZARD_WB_BYPASS_EN
  localparam logic WB_BYPASS = 1'b1;
`else
  localparam logic WB_BYPASS = 1'b0;
`endif

  slot_t     ex_q, mem_q, wb_q;
  slot_t     ex_d;
  logic      ex_load_s;
  logic      load_use_s;
  logic      wb_memread_unused;
  hz_state_t state_q, state_d;
  fwd_sel_t  fwd_a_s, fwd_b_s;

  // The load flag only matters while the producer sits in EX.
  assign wb_memread_unused = wb_q.memread;

  // Youngest producer wins: EX, then MEM, then (optionally) WB.
  function automatic fwd_sel_t pick_src(logic [ADDR_W-1:0] src, slot_t ex,
                                        slot_t mem, slot_t wb);
    fwd_sel_t sel;
    if (src == ZERO_REG) begin
      sel = FWD_RF;
    end else if (slot_matches(ex, src)) begin
      sel = FWD_EX;
    end else if (slot_matches(mem, src)) begin
      sel = FWD_MEM;
    end else if (WB_BYPASS && slot_matches(wb, src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Hazard decisions: load-use detect, stall, EX entry and forwarding selects.
  always_comb begin
    load_use_s = 1'b0;
    stall      = 1'b0;
    ex_load_s  = 1'b0;
    ex_d       = SLOT_BUBBLE;
    fwd_a_s    = FWD_RF;
    fwd_b_s    = FWD_RF;
    state_d    = RUN;

    load_use_s = ex_q.valid && ex_q.memread &&
                 (slot_matches(ex_q, id_rn) || slot_matches(ex_q, id_rm));

    // Only one stall per load: the STALL cycle never re-asserts it, and a
    // flush squashes the consumer so there is nothing to protect.
    if (state_q == RUN) begin
      stall = id_valid && load_use_s && !flush;
    end else begin
      stall = 1'b0;
    end

    if (stall) begin
      state_d = STALL;
    end else begin
      state_d = RUN;
    end

    ex_load_s = id_valid && id_regwrite && (id_rd != ZERO_REG) && !stall && !flush;
    ex_d      = '{valid: 1'b1, rd: id_rd, memread: id_memread};

    // The consumer is being held, so its operands are irrelevant this cycle.
    if (stall) begin
      fwd_a_s = FWD_RF;
      fwd_b_s = FWD_RF;
    end else begin
      fwd_a_s = pick_src(id_rn, ex_q, mem_q, wb_q);
      fwd_b_s = pick_src(id_rm, ex_q, mem_q, wb_q);
    end
  end

  assign fwd_a = fwd_a_s;
  assign fwd_b = fwd_b_s;

  // Stall FSM state register; reset returns to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_slot u_ex (
    .clk   (clk),
    .reset (reset),
    .load  (ex_load_s),
    .d     (ex_d),
    .q     (ex_q)
  );

  pipe_slot u_mem (
    .clk   (clk),
    .reset (reset),
    .load  (1'b1),
    .d     (ex_q),
    .q     (mem_q)
  );

  pipe_slot u_wb (
    .clk   (clk),
    .reset (reset),
    .load  (1'b1),
    .d     (mem_q),
    .q     (wb_q)
  );

endmodule
